// File: rtl/main_seq_pkg.sv
// main_seq_pkg: shared encodings for the main accelerator run sequencer
package main_seq_pkg;
    typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_RUN = 2'd1, OP_READ = 2'd2, OP_BAD = 2'd3} op_e;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_HUNG = 2'd2, ST_BADOP = 2'd3} status_e;
    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, RUN_START, RUN_WAIT, RESP} state_e;
    localparam int NUM_CH = 2;
    localparam int CH0 = 0;
endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter: loadable saturating up-counter with a limit compare
module seq_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (load) count <= load_val;
        else if (inc && count != '1) count <= count + CNT_W'(1);
    assign at_limit = count >= limit;
endmodule

// File: rtl/main_run_sequencer.sv
// main_run_sequencer: command-driven write/run/read sequencer for the main accelerator
module main_run_sequencer
    import main_seq_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 7,
    parameter int CNT_W = 32,
    parameter int unsigned RUN_TIMEOUT = 200000000,
    parameter int unsigned MEM_TIMEOUT = 16,
    localparam int RSP_W = (DATA_W > CNT_W) ? DATA_W : CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic [SIZE_W-1:0]        cmd_size,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RSP_W-1:0]         rsp_data,
    output logic [1:0]               rsp_status,
    output logic                     start_port,
    input  logic                     done_port,
    output logic [NUM_CH-1:0]        S_oe_ram,
    output logic [NUM_CH-1:0]        S_we_ram,
    output logic [NUM_CH*ADDR_W-1:0] S_addr_ram,
    output logic [NUM_CH*DATA_W-1:0] S_Wdata_ram,
    output logic [NUM_CH*SIZE_W-1:0] S_data_ram_size,
    input  logic [NUM_CH*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [NUM_CH-1:0]        Sout_DataRdy
);
    if (CNT_W < 64 && 64'(RUN_TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("RUN_TIMEOUT must be below 2**CNT_W");
    end
    state_e state, state_nx;
    op_e op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [SIZE_W-1:0] size_q;
    logic hung;
    logic mem_req;
    logic [CNT_W-1:0] count;
    logic at_limit;
    logic rdy;
    logic unused_in;
    assign unused_in = ^{Sout_Rdata_ram[NUM_CH*DATA_W-1:DATA_W], Sout_DataRdy[NUM_CH-1:1]};
    assign rdy = Sout_DataRdy[CH0];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cmd_valid) state_nx = (hung || cmd_op == OP_BAD) ? RESP : (cmd_op == OP_RUN) ? RUN_START : MEM_REQ;
            MEM_REQ:   state_nx = MEM_WAIT;
            MEM_WAIT:  if (rdy || at_limit) state_nx = RESP;
            RUN_START: state_nx = RUN_WAIT;
            RUN_WAIT:  if (done_port || at_limit) state_nx = RESP;
            RESP:      if (rsp_ready) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    // Response registers are written on every wait cycle; the value on the exit cycle is what RESP holds.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            hung <= 1'b0;
            op_q <= OP_WRITE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            rsp_data <= '0;
            rsp_status <= ST_OK;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q <= op_e'(cmd_op);
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                size_q <= cmd_size;
                if (hung || cmd_op == OP_BAD) begin
                    rsp_data <= '0;
                    rsp_status <= hung ? ST_HUNG : ST_BADOP;
                end
            end
            if (state == MEM_WAIT) begin
                rsp_data <= (rdy && op_q == OP_READ) ? RSP_W'(Sout_Rdata_ram[DATA_W-1:0]) : '0;
                rsp_status <= rdy ? ST_OK : ST_TIMEOUT;
            end
            if (state == RUN_WAIT) begin
                rsp_data <= done_port ? RSP_W'(count + CNT_W'(1)) : RSP_W'(RUN_TIMEOUT);
                rsp_status <= done_port ? ST_OK : ST_TIMEOUT;
                hung <= hung | (!done_port & at_limit);
            end
        end
    // The counter holds completed cycles, so the run limit sits one below RUN_TIMEOUT.
    seq_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock,
        .reset,
        .load(state == MEM_REQ || state == RUN_START),
        .inc(state == MEM_WAIT || state == RUN_WAIT),
        .load_val(CNT_W'(1)),
        .limit(state == RUN_WAIT ? CNT_W'(RUN_TIMEOUT - 1) : CNT_W'(MEM_TIMEOUT)),
        .count,
        .at_limit
    );
    assign mem_req = state == MEM_REQ;
    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign start_port = state == RUN_START;
    assign S_we_ram = NUM_CH'(mem_req && op_q == OP_WRITE);
    assign S_oe_ram = NUM_CH'(mem_req && op_q == OP_READ);
    assign S_addr_ram = mem_req ? (NUM_CH*ADDR_W)'(addr_q) : '0;
    assign S_Wdata_ram = mem_req ? (NUM_CH*DATA_W)'(data_q) : '0;
    assign S_data_ram_size = mem_req ? (NUM_CH*SIZE_W)'(size_q) : '0;
endmodule
